dram_arbiter: RTL
=================

Name: dram_arbiter

Overview:
- Shares the single-port DRAM between the four processor cores and the host/file load-readback port.
- Accepts at most one access per cycle and registers it toward the DRAM.
- Routes read data back to the requester that issued the read.
- Sits between the core memory interfaces and the DRAM inside the top-level module. It replaces direct DRAM muxing on the host port.

Parameters:
- N_CORES, 4, number of core requesters (1..4).
- ADDR_W, 12, DRAM address width.
- DATA_W, 32, DRAM data width.
- RD_LAT, 1, DRAM read latency in cycles from registered mem_addr to valid mem_rdata (1..3).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- host_req  in  1  host access request; held until host_gnt.
- host_we  in  1  host write enable.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_gnt  out  1  one-cycle pulse: host access issued.
- host_rvalid  out  1  one-cycle pulse: host read data valid.
- core_en  in  N_CORES  per-core enable; a disabled core's request is ignored.
- core_req  in  N_CORES  per-core request; held until its core_gnt.
- core_we  in  N_CORES  per-core write enable.
- core_addr  in  N_CORES*ADDR_W  packed addresses, core i at bits [i*ADDR_W +: ADDR_W].
- core_wdata  in  N_CORES*DATA_W  packed write data, same packing.
- core_gnt  out  N_CORES  one-hot one-cycle grant pulse.
- core_rvalid  out  N_CORES  one-hot one-cycle read-data-valid pulse.
- rdata  out  DATA_W  shared read-data bus, qualified by host_rvalid/core_rvalid.
- mem_addr  out  ADDR_W  registered DRAM address.
- mem_we  out  1  registered DRAM write enable.
- mem_wdata  out  DATA_W  registered DRAM write data.
- mem_rdata  in  DATA_W  DRAM read data.
- busy  out  1  high while any read is in flight or any enabled request is pending.

Behaviour:
- Reset (async, rst_n=0) sets these to 0: all gnt/rvalid outputs, mem_we, mem_addr, mem_wdata, rdata.
- Reset also clears the read-tracking pipeline and sets the round-robin pointer to core 0.
- Reset asserted mid-operation drops in-flight reads; no rvalid is produced for them.
- Arbitration each cycle; eligible requesters:
  - host if host_req=1;
  - core i if core_req[i]=1, core_en[i]=1 and i < N_CORES.
- A requester whose gnt is high this cycle is excluded, so a held req is never double-granted.
- Priority: host is fixed highest. Cores use round-robin starting at the pointer.
- After a core grant, the pointer becomes (granted index + 1) mod N_CORES. A host grant leaves the pointer unchanged.
- Grant cycle (edge k): the winner's addr/we/wdata are registered onto mem_* and its gnt pulses high during cycle k+1. The requester may change or drop req from cycle k+1 onward.
- No eligible requester: mem_we=0. mem_addr and mem_wdata hold their previous values.
- Writes: mem_we is high for exactly one cycle per granted write. No response is returned.
- Reads: the requester id (host or core index) plus a valid bit enter an RD_LAT-deep shift register aligned with mem_rdata.
  - At the output, rdata is registered from mem_rdata and the matching rvalid pulses.
  - Total latency: gnt cycle + RD_LAT + 1 cycle to rvalid.
  - Reads are fully pipelined: back-to-back reads from different requesters return in issue order.
- Throughput: one access per cycle. A single core holding req continuously is granted at most every other cycle.
- core_en dropping while a read is in flight: the read still completes and rvalid is delivered.
- busy = any pipeline valid bit set OR any eligible request.

Decomposition:
- Shared package holds:
  - requester id encoding: HOST_ID = N_CORES, cores 0..N_CORES-1;
  - ID_W = clog2(N_CORES+1);
  - default ADDR_W/DATA_W constants also used by the top level and cores.
- One sub-module, rr_pick: a combinational round-robin priority selector taking request vector and pointer, returning a one-hot grant plus index.

Test Plan:
- Host-only, RD_LAT=1: host writes 0x0000002A to addr 0x010, then reads 0x010.
  -> One mem_we pulse with mem_addr=0x010.
  -> host_rvalid pulses exactly 2 cycles after the read's host_gnt, with rdata=0x0000002A.
- All four cores request reads continuously, pointer at 0.
  -> Grant order 0,1,2,3,0,…
  -> Each core receives one grant in every 4 grants.
  -> core_rvalid order matches grant order.
- Host and cores 1,3 request in the same cycle.
  -> host_gnt first, then core 1, then core 3.
  -> Pointer is unchanged by the host grant.
- core_en=4'b0101 and all core_req high.
  -> Only cores 0 and 2 are ever granted, alternating.
  -> Cores 1 and 3 get no gnt and no rvalid.
- Single core 2 holds req with we=0 for 6 cycles.
  -> core_gnt[2] is high every other cycle only.
  -> 3 reads are issued, each with a matching core_rvalid[2].
- Reset asserted 1 cycle after a read grant (RD_LAT=2).
  -> All outputs are 0 immediately.
  -> No core_rvalid for the dropped read; pointer=0 after release.

Source files
------------

// File: rtl/dram_arbiter_pkg.sv
// Shared constants and types for the DRAM arbiter and its neighbours.
package dram_arbiter_pkg;

  localparam int unsigned DEF_N_CORES = 4;
  localparam int unsigned DEF_ADDR_W  = 12;
  localparam int unsigned DEF_DATA_W  = 32;

  // Requester id: cores 0..N_CORES-1, host = N_CORES; sized for the largest legal core count.
  localparam int unsigned ID_W = $clog2(DEF_N_CORES + 1);

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } rd_tag_t;

  // Host requester id for a given core count.
  function automatic logic [ID_W-1:0] host_id(input int unsigned n_cores);
    return ID_W'(n_cores);
  endfunction

endpackage

// File: rtl/dram_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping.
module dram_arbiter_rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt_c,
  output logic [IDX_W-1:0] idx_c,
  output logic             any_c
);

  // Scan N positions starting at ptr, take the first requester found.
  always_comb begin
    int unsigned j;
    gnt_c = '0;
    idx_c = '0;
    any_c = 1'b0;
    j     = 0;
    for (int unsigned off = 0; off < N; off++) begin
      j = (32'(ptr) + off) % N;
      if (!any_c && req[j]) begin
        any_c    = 1'b1;
        gnt_c[j] = 1'b1;
        idx_c    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Single-port DRAM arbiter: host (fixed priority) plus round-robin cores,
// one registered access per cycle, read data routed back by a tag pipeline.
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int unsigned N_CORES = DEF_N_CORES,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        host_req,
  input  logic                        host_we,
  input  logic [ADDR_W-1:0]           host_addr,
  input  logic [DATA_W-1:0]           host_wdata,
  output logic                        host_gnt,
  output logic                        host_rvalid,
  input  logic [N_CORES-1:0]          core_en,
  input  logic [N_CORES-1:0]          core_req,
  input  logic [N_CORES-1:0]          core_we,
  input  logic [N_CORES*ADDR_W-1:0]   core_addr,
  input  logic [N_CORES*DATA_W-1:0]   core_wdata,
  output logic [N_CORES-1:0]          core_gnt,
  output logic [N_CORES-1:0]          core_rvalid,
  output logic [DATA_W-1:0]           rdata,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_we,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        busy
);

  localparam int unsigned   PTR_W    = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam logic [ID_W-1:0] HOST_TAG = host_id(N_CORES);

  logic [PTR_W-1:0]          rr_ptr;
  logic                      host_elig_c;
  logic [N_CORES-1:0]        core_elig_c;
  logic [N_CORES-1:0]        pick_gnt_c;
  logic [PTR_W-1:0]          pick_idx_c;
  logic                      pick_any_c;
  logic [ADDR_W-1:0]         win_addr_c;
  logic [DATA_W-1:0]         win_wdata_c;
  logic [PTR_W-1:0]          ptr_next_c;
  logic [ID_W-1:0]           gnt_id;
  logic                      rd_issue_c;
  rd_tag_t [RD_LAT-1:0]      rd_pipe;
  rd_tag_t                   rd_out_c;

  // Eligibility: a requester already showing gnt this cycle is skipped.
  assign host_elig_c = host_req & ~host_gnt;
  assign core_elig_c = core_req & core_en & ~core_gnt;

  dram_arbiter_rr_pick #(
    .N     (N_CORES),
    .IDX_W (PTR_W)
  ) u_rr_pick (
    .req   (core_elig_c),
    .ptr   (rr_ptr),
    .gnt_c (pick_gnt_c),
    .idx_c (pick_idx_c),
    .any_c (pick_any_c)
  );

  // Winning core payload and the pointer value following it.
  always_comb begin
    win_addr_c  = core_addr[32'(pick_idx_c) * ADDR_W +: ADDR_W];
    win_wdata_c = core_wdata[32'(pick_idx_c) * DATA_W +: DATA_W];
    ptr_next_c  = (pick_idx_c == PTR_W'(N_CORES - 1)) ? '0 : pick_idx_c + PTR_W'(1);
  end

  // Grant register: issue the winner onto the DRAM bus and pulse its gnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_gnt  <= 1'b0;
      core_gnt  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rr_ptr    <= '0;
      gnt_id    <= '0;
    end else begin
      host_gnt <= 1'b0;
      core_gnt <= '0;
      mem_we   <= 1'b0;
      if (host_elig_c) begin
        host_gnt  <= 1'b1;
        mem_we    <= host_we;
        mem_addr  <= host_addr;
        mem_wdata <= host_wdata;
        gnt_id    <= HOST_TAG;
      end else if (pick_any_c) begin
        core_gnt  <= pick_gnt_c;
        mem_we    <= core_we[pick_idx_c];
        mem_addr  <= win_addr_c;
        mem_wdata <= win_wdata_c;
        gnt_id    <= ID_W'(pick_idx_c);
        rr_ptr    <= ptr_next_c;
      end
    end
  end

  // A read is on the DRAM bus during its gnt cycle.
  assign rd_issue_c = (host_gnt | (|core_gnt)) & ~mem_we;
  assign rd_out_c   = rd_pipe[RD_LAT-1];

  // Tag pipeline: last stage lines up with valid mem_rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe[0] <= '{vld: rd_issue_c, id: gnt_id};
      for (int unsigned j = 1; j < RD_LAT; j++) begin
        rd_pipe[j] <= rd_pipe[j-1];
      end
    end
  end

  // Response register: capture read data and pulse the owner's rvalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_rvalid <= 1'b0;
      core_rvalid <= '0;
      rdata       <= '0;
    end else begin
      host_rvalid <= 1'b0;
      core_rvalid <= '0;
      if (rd_out_c.vld) begin
        rdata <= mem_rdata;
        if (rd_out_c.id == HOST_TAG) begin
          host_rvalid <= 1'b1;
        end else begin
          core_rvalid <= N_CORES'(1) << rd_out_c.id;
        end
      end
    end
  end

  // Activity: reads in flight or requests waiting.
  always_comb begin
    busy = rd_issue_c | host_elig_c | (|core_elig_c);
    for (int unsigned j = 0; j < RD_LAT; j++) begin
      busy = busy | rd_pipe[j].vld;
    end
  end

endmodule
